// File: rtl/alu_pkg.sv
// Opcode encodings and helpers shared by the pipelined ALU, its core and its interface.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd1;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd2;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd3;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd4;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd5;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd7;
  localparam logic [OP_W-1:0] OP_OR    = 6'd8;
  localparam logic [OP_W-1:0] OP_AND   = 6'd9;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd10;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd11;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd12;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd13;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd14;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd16;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd17;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd18;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd19;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd20;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd21;

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: is_branch = 1'b1;
      default:                                          is_branch = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_unit_if.sv
// Issue-side and write-back-side handshake bundle of the pipelined ALU.
interface alu_pipe_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [alu_pkg::OP_W-1:0]  in_op;
  logic [XLEN-1:0]           in_rs1;
  logic [XLEN-1:0]           in_rs2;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [TAG_W-1:0]          out_tag;
  logic [XLEN-1:0]           out_val;
  logic                      out_taken;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_val, out_taken
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_val, out_taken
  );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (op, a, b) -> (result, branch taken).
module alu_core import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] val_o,
  output logic            taken_o
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt_s;
  logic            lt_s;
  logic            ltu_s;
  logic            cond_s;

  assign shamt_s = b_i[SH_W-1:0];
  assign lt_s    = $signed(a_i) < $signed(b_i);
  assign ltu_s   = a_i < b_i;

  // Branch condition evaluation
  always_comb begin
    cond_s = 1'b0;
    case (op_i)
      OP_BEQ:  cond_s = (a_i == b_i);
      OP_BNE:  cond_s = (a_i != b_i);
      OP_BLT:  cond_s = lt_s;
      OP_BGE:  cond_s = ~lt_s;
      OP_BLTU: cond_s = ltu_s;
      OP_BGEU: cond_s = ~ltu_s;
      default: cond_s = 1'b0;
    endcase
  end

  // Result selection; branches report their condition as a zero-extended value
  always_comb begin
    val_o = {XLEN{1'b0}};
    case (op_i)
      OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: val_o = a_i + b_i;
      OP_SUB:  val_o = a_i - b_i;
      OP_XOR:  val_o = a_i ^ b_i;
      OP_OR:   val_o = a_i | b_i;
      OP_AND:  val_o = a_i & b_i;
      OP_SLL:  val_o = a_i << shamt_s;
      OP_SRL:  val_o = a_i >> shamt_s;
      OP_SRA:  val_o = XLEN'($signed(a_i) >>> shamt_s);
      OP_SLT:  val_o = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: val_o = {{(XLEN-1){1'b0}}, ltu_s};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
               val_o = {{(XLEN-1){1'b0}}, cond_s};
      default: val_o = {XLEN{1'b0}};
    endcase
  end

  assign taken_o = is_branch(op_i) & cond_s;

endmodule

// File: rtl/alu_pipe_unit.sv
// Pipelined ALU: one registered execute stage (E1) feeding a DEPTH-entry result FIFO
// that drains to the CDB under a valid/ready grant.
module alu_pipe_unit import alu_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear,
  alu_pipe_unit_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic             e1_valid_q;
  logic [TAG_W-1:0] e1_tag_q;
  logic [XLEN-1:0]  e1_val_q;
  logic             e1_taken_q;

  logic [TAG_W-1:0] tag_mem_q   [DEPTH];
  logic [XLEN-1:0]  val_mem_q   [DEPTH];
  logic             taken_mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic [XLEN-1:0]  core_val_s;
  logic             core_taken_s;
  logic [CW:0]      occupancy_s;
  logic             out_valid_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;

  alu_core #(.XLEN(XLEN)) u_core (
    .op_i    (bus.in_op),
    .a_i     (bus.in_rs1),
    .b_i     (bus.in_rs2),
    .val_o   (core_val_s),
    .taken_o (core_taken_s)
  );

  // The op in E1 counts against capacity so it always has a FIFO slot waiting.
  assign occupancy_s  = {1'b0, count_q} + {{CW{1'b0}}, e1_valid_q};
  assign bus.in_ready = occupancy_s < DEPTH_C;
  assign out_valid_s  = (count_q != {CW{1'b0}});
  assign accept_s     = bus.in_valid & bus.in_ready & rdy_in & ~clear;
  assign push_s       = e1_valid_q & rdy_in & ~clear;
  assign pop_s        = out_valid_s & bus.out_ready & rdy_in & ~clear;

  assign bus.out_valid = out_valid_s;
  assign bus.out_tag   = tag_mem_q[rd_ptr_q];
  assign bus.out_val   = val_mem_q[rd_ptr_q];
  assign bus.out_taken = taken_mem_q[rd_ptr_q];

  // Execute stage register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      e1_valid_q <= 1'b0;
      e1_tag_q   <= {TAG_W{1'b0}};
      e1_val_q   <= {XLEN{1'b0}};
      e1_taken_q <= 1'b0;
    end else if (clear) begin
      e1_valid_q <= 1'b0;
    end else if (rdy_in) begin
      e1_valid_q <= accept_s;
      if (accept_s) begin
        e1_tag_q   <= bus.in_tag;
        e1_val_q   <= core_val_s;
        e1_taken_q <= core_taken_s;
      end
    end
  end

  // Result FIFO storage, pointers and occupancy
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]   <= {TAG_W{1'b0}};
        val_mem_q[i]   <= {XLEN{1'b0}};
        taken_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_q[wr_ptr_q]   <= e1_tag_q;
        val_mem_q[wr_ptr_q]   <= e1_val_q;
        taken_mem_q[wr_ptr_q] <= e1_taken_q;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Randomised + directed bench for alu_pipe_unit against a transaction-level queue model.
module tb_alu_pipe_unit;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] val;
    logic        taken;
  } res_t;

  logic clk_in, rst_in, rdy_in, clear;
  int   checks, errors;

  alu_pipe_unit_if #(.XLEN(32), .TAG_W(4)) bus ();

  alu_pipe_unit #(.XLEN(32), .TAG_W(4), .DEPTH(DEPTH)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU written from the arithmetic rules, not from the RTL datapath
  function automatic res_t ref_alu(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
    res_t        r;
    logic [31:0] v;
    logic [31:0] as, bs;
    bit          br, c;
    int          sh;
    sh = int'(b[4:0]);
    as = a ^ 32'h8000_0000;
    bs = b ^ 32'h8000_0000;
    v  = 32'h0;
    br = 1'b0;
    c  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: v = a + b;
      OP_SUB:  v = a - b;
      OP_XOR:  v = a ^ b;
      OP_OR:   v = a | b;
      OP_AND:  v = a & b;
      OP_SLL:  v = a << sh;
      OP_SRL:  v = a >> sh;
      OP_SRA:  v = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      OP_SLT:  v = (as < bs) ? 32'h1 : 32'h0;
      OP_SLTU: v = (a < b) ? 32'h1 : 32'h0;
      OP_BEQ:  begin br = 1'b1; c = (a == b);  end
      OP_BNE:  begin br = 1'b1; c = (a != b);  end
      OP_BLT:  begin br = 1'b1; c = (as < bs); end
      OP_BGE:  begin br = 1'b1; c = !(as < bs); end
      OP_BLTU: begin br = 1'b1; c = (a < b);   end
      OP_BGEU: begin br = 1'b1; c = !(a < b);  end
      default: v = 32'h0;
    endcase
    if (br) v = {31'h0, c};
    r.tag   = tag;
    r.val   = v;
    r.taken = br & c;
    return r;
  endfunction

  // Model: one pending result (the op accepted last cycle) plus an in-order result queue
  res_t q[$];
  bit   pend_v;
  res_t pend;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      q.delete();
      pend_v = 1'b0;
    end else begin
      bit acc;
      acc = bus.in_valid && ((q.size() + int'(pend_v)) < DEPTH) && rdy_in && !clear;
      if (clear) begin
        q.delete();
        pend_v = 1'b0;
      end else if (rdy_in) begin
        if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
        if (pend_v) q.push_back(pend);
        pend_v = acc;
        if (acc) pend = ref_alu(bus.in_op, bus.in_rs1, bus.in_rs2, bus.in_tag);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk_in) begin
    if (rst_in) begin
      check("in_ready", 32'(bus.in_ready), 32'(((q.size() + int'(pend_v)) < DEPTH) ? 1 : 0));
      check("out_valid", 32'(bus.out_valid), 32'((q.size() > 0) ? 1 : 0));
      if (q.size() > 0) begin
        check("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
        check("out_val", bus.out_val, q[0].val);
        check("out_taken", 32'(bus.out_taken), 32'(q[0].taken));
      end
    end
  end

  task automatic set_op(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
    bus.in_op  = op;
    bus.in_rs1 = a;
    bus.in_rs2 = b;
    bus.in_tag = tag;
  endtask

  // Present one op and hold it until the DUT takes it (bounded)
  task automatic issue(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    bit done;
    done = 1'b0;
    set_op(op, a, b, tag);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_in);
      done = bus.in_ready;
      @(posedge clk_in);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("issue_timeout", 32'h0, 32'h1);
  endtask

  // Single op through an empty unit with literal expected result and two-cycle latency
  task automatic single(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] exp_val, input logic exp_taken);
    int n;
    issue(op, a, b, tag);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      n++;
      if (bus.out_valid) break;
    end
    check({name, "_latency"}, 32'(n), 32'd2);
    check({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
    check({name, "_val"}, bus.out_val, exp_val);
    check({name, "_taken"}, 32'(bus.out_taken), 32'(exp_taken));
    @(posedge clk_in);
    #1;
  endtask

  logic [5:0] ops [22];

  initial begin
    int n;
    checks = 0;
    errors = 0;
    ops = '{OP_ADD, OP_ADDI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SUB, OP_XOR, OP_OR,
            OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_BEQ, OP_BNE, OP_BLT,
            OP_BGE, OP_BLTU, OP_BGEU, 6'd63};
    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(OP_ADD, 32'h0, 32'h0, 4'h0);
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_tag", 32'(bus.out_tag), 32'h0);
    check("rst_out_val", bus.out_val, 32'h0);
    check("rst_out_taken", 32'(bus.out_taken), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    single("add",   OP_ADD,  32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
    @(negedge clk_in);
    check("add_popped", 32'(bus.out_valid), 32'h0);
    @(posedge clk_in);
    #1;
    single("sra",   OP_SRA,  32'h8000_0000, 32'd4, 4'd4, 32'hF800_0000, 1'b0);
    single("srl",   OP_SRL,  32'h8000_0000, 32'd4, 4'd5, 32'h0800_0000, 1'b0);
    single("sra0",  OP_SRA,  32'h8765_4321, 32'd32, 4'd6, 32'h8765_4321, 1'b0);
    single("blt",   OP_BLT,  32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1, 1'b1);
    single("bltu",  OP_BLTU, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd0, 1'b0);
    single("bge",   OP_BGE,  32'd0, 32'd0, 4'd9, 32'd1, 1'b1);
    single("undef", 6'd63,   32'd9, 32'd9, 4'd10, 32'd0, 1'b0);

    // Back-pressure: only DEPTH ops fit while the CDB is stalled
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      set_op(OP_ADD, 32'(i), 32'd100, 4'(n));
      @(negedge clk_in);
      if (bus.in_ready) n++;
      @(posedge clk_in);
      #1;
    end
    check("bp_accepts", 32'(n), 32'd4);
    check("bp_in_ready", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_op(ops[$urandom_range(0, 21)], $urandom, $urandom, 4'(n + i));
      @(posedge clk_in);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk_in);
    #1;

    // Flush with E1 busy and three results queued
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(OP_XOR, 32'(i), 32'hFF, 4'(i + 1));
      @(posedge clk_in);
      #1;
    end
    bus.in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk_in);
    check("pre_clear_valid", 32'(bus.out_valid), 32'h1);
    @(posedge clk_in);
    #1;
    clear = 1'b0;
    @(negedge clk_in);
    check("post_clear_valid", 32'(bus.out_valid), 32'h0);
    check("post_clear_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk_in);
    #1;
    bus.out_ready = 1'b1;
    single("after_clear", OP_SUB, 32'd10, 32'd3, 4'd14, 32'd7, 1'b0);

    // Freeze: head stays put while rdy_in is low even with a grant
    bus.out_ready = 1'b0;
    issue(OP_OR, 32'hF0, 32'h0F, 4'd9);
    issue(OP_OR, 32'h01, 32'h02, 4'd10);
    repeat (2) @(posedge clk_in);
    #1;
    rdy_in = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_op(OP_ADD, 32'd1, 32'd1, 4'd11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("frz_valid", 32'(bus.out_valid), 32'h1);
      check("frz_tag", 32'(bus.out_tag), 32'd9);
      check("frz_val", bus.out_val, 32'hFF);
      @(posedge clk_in);
      #1;
    end
    rdy_in = 1'b1;
    bus.in_valid = 1'b0;

    // Asynchronous reset in the middle of traffic
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'd2, 32'd2, 4'd12);
    issue(OP_BEQ, 32'd2, 32'd2, 4'd13);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_tag", 32'(bus.out_tag), 32'h0);
    check("mid_rst_val", bus.out_val, 32'h0);
    check("mid_rst_taken", 32'(bus.out_taken), 32'h0);
    #4;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Random traffic with stalls, freezes and flushes
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rdy_in        = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 49) == 0);
      set_op(ops[$urandom_range(0, 21)], a,
             ($urandom_range(0, 3) == 0) ? a : $urandom, 4'($urandom));
      @(posedge clk_in);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rdy_in        = 1'b1;
    clear         = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check("drained", 32'(bus.out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
